gp_cmd_fifo: RTL and testbench

//  Buffers draw commands between game_controller and graphics_processor.
//  - Producer side: game_controller bursts rectangle fill/blit commands without waiting on gp_finish.
//  - Consumer side: a dispatcher FSM issues one command at a time to graphics_processor and waits for gp_finish.
//  - Also rejects off-screen or inverted rectangles, and recovers from a hung graphics_processor via a watchdog.

---
 rtl/gp_cmd_fifo_if.sv | 40 ++++
 rtl/gp_cmd_fifo.sv | 134 +++++++++++++
 tb/tb_gp_cmd_fifo.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gp_cmd_fifo_if.sv
// Command bus between game_controller (producer), gp_cmd_fifo and graphics_processor.
// The slave modport is the FIFO/dispatcher side; master is the producer/consumer side.
interface gp_cmd_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                flush;
  logic                push;
  logic                in_opcode;
  logic [9:0]          in_tl_x;
  logic [8:0]          in_tl_y;
  logic [9:0]          in_br_x;
  logic [8:0]          in_br_y;
  logic [11:0]         in_arg;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                gp_finish;
  logic                gp_en;
  logic                gp_opcode;
  logic [9:0]          gp_tl_x;
  logic [8:0]          gp_tl_y;
  logic [9:0]          gp_br_x;
  logic [8:0]          gp_br_y;
  logic [11:0]         gp_arg;
  logic                busy;
  logic                overflow;
  logic                reject;
  logic                timeout_err;

  modport master (
    output flush, push, in_opcode, in_tl_x, in_tl_y, in_br_x, in_br_y, in_arg, gp_finish,
    input  full, count, gp_en, gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg,
    input  busy, overflow, reject, timeout_err
  );

  modport slave (
    input  flush, push, in_opcode, in_tl_x, in_tl_y, in_br_x, in_br_y, in_arg, gp_finish,
    output full, count, gp_en, gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg,
    output busy, overflow, reject, timeout_err
  );
endinterface

// File: rtl/gp_cmd_fifo.sv
// Draw-command FIFO with rectangle validation and a single-command dispatcher
// that hands commands to graphics_processor, with a watchdog for hung commands.
module gp_cmd_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input logic          clk,
  input logic          rst,
  gp_cmd_fifo_if.slave bus
);
  localparam int unsigned     Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned     WdW    = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0]  WdLast = WdW'(TIMEOUT - 1);

  typedef struct packed {
    logic        opcode;
    logic [9:0]  tl_x;
    logic [8:0]  tl_y;
    logic [9:0]  br_x;
    logic [8:0]  br_y;
    logic [11:0] arg;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  cmd_t                  mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  state_e                state_q;
  logic [WdW-1:0]        wdog_q;
  cmd_t                  cmd_q;
  logic                  gp_en_q, overflow_q, reject_q, timeout_q;

  cmd_t in_cmd;
  logic full, rect_ok, push_acc, pop;

  assign in_cmd   = {bus.in_opcode, bus.in_tl_x, bus.in_tl_y, bus.in_br_x, bus.in_br_y,
                     bus.in_arg};
  assign full     = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign rect_ok  = (in_cmd.tl_x <= in_cmd.br_x) && (in_cmd.tl_y <= in_cmd.br_y) &&
                    (in_cmd.br_x <= 10'd639) && (in_cmd.br_y <= 9'd479);
  assign push_acc = bus.push && !full && !bus.flush && rect_ok;
  // A flush drops everything not yet issued, including the head the FSM would take.
  assign pop      = (state_q == StIdle) && (count_q != '0) && !bus.flush;

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop) begin
      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    end else if (!push_acc && pop) begin
      count_d = count_q - (DEPTH_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wptr_q] <= in_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_acc) wptr_q <= wptr_q + DEPTH_LOG2'(1);
      if (pop)      rptr_q <= rptr_q + DEPTH_LOG2'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      reject_q   <= 1'b0;
    end else if (bus.push && !bus.flush) begin
      if (full)     overflow_q <= 1'b1;
      if (!rect_ok) reject_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gp_en_q   <= 1'b0;
      cmd_q     <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            cmd_q   <= mem_q[rptr_q];
            gp_en_q <= 1'b1;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          wdog_q <= wdog_q + WdW'(1);
          if (bus.gp_finish) begin
            gp_en_q <= 1'b0;
            state_q <= StGap;
          end else if (wdog_q == WdLast) begin
            gp_en_q   <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StGap;
          end
        end
        StGap: begin
          // Guarantees graphics_processor sees gp_en low before the next command.
          wdog_q  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.full        = full;
  assign bus.count       = count_q;
  assign bus.gp_en       = gp_en_q;
  assign bus.gp_opcode   = cmd_q.opcode;
  assign bus.gp_tl_x     = cmd_q.tl_x;
  assign bus.gp_tl_y     = cmd_q.tl_y;
  assign bus.gp_br_x     = cmd_q.br_x;
  assign bus.gp_br_y     = cmd_q.br_y;
  assign bus.gp_arg      = cmd_q.arg;
  assign bus.busy        = (state_q != StIdle) || (count_q != '0);
  assign bus.overflow    = overflow_q;
  assign bus.reject      = reject_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_gp_cmd_fifo.sv
// Randomised bench for gp_cmd_fifo: a queue-based reference model predicts the command
// stream and status; a monitor checks each issued command against a scoreboard queue.
module tb_gp_cmd_fifo;
  localparam int unsigned Dl2   = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned Tmo   = 20;

  typedef struct packed {
    logic        opcode;
    logic [9:0]  tl_x;
    logic [8:0]  tl_y;
    logic [9:0]  br_x;
    logic [8:0]  br_y;
    logic [11:0] arg;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gp_cmd_fifo_if #(.DEPTH_LOG2(Dl2)) bus ();

  gp_cmd_fifo #(.DEPTH_LOG2(Dl2), .TIMEOUT(Tmo)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rect_valid(input cmd_t c);
    return (int'(c.tl_x) <= int'(c.br_x)) && (int'(c.tl_y) <= int'(c.br_y)) &&
           (int'(c.br_x) < 640) && (int'(c.br_y) < 480);
  endfunction

  function automatic cmd_t cur_in();
    return {bus.in_opcode, bus.in_tl_x, bus.in_tl_y, bus.in_br_x, bus.in_br_y, bus.in_arg};
  endfunction

  function automatic cmd_t cur_gp();
    return {bus.gp_opcode, bus.gp_tl_x, bus.gp_tl_y, bus.gp_br_x, bus.gp_br_y, bus.gp_arg};
  endfunction

  // Reference model: queued commands, what is on the gp bus, and sticky flags.
  cmd_t mq[$];
  cmd_t exp_q[$];
  int   m_phase   = 0;  // 0 idle, 1 executing, 2 gap
  int   m_elapsed = 0;
  bit   m_en = 0, m_ovf = 0, m_rej = 0, m_tmo = 0;
  cmd_t m_cmd = '0;

  always @(posedge clk) begin
    cmd_t c;
    bit   was_full, issue;
    c = cur_in();
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_phase = 0; m_elapsed = 0; m_en = 0; m_cmd = '0;
      m_ovf = 0; m_rej = 0; m_tmo = 0;
    end else begin
      was_full = (mq.size() == Depth);
      issue    = (m_phase == 0) && (mq.size() != 0) && !bus.flush;
      if (bus.push && !bus.flush) begin
        if (was_full)       m_ovf = 1;
        if (!rect_valid(c)) m_rej = 1;
      end
      case (m_phase)
        0: if (issue) begin
          m_cmd = mq.pop_front();
          exp_q.push_back(m_cmd);
          m_en = 1; m_phase = 1; m_elapsed = 0;
        end
        1: begin
          m_elapsed++;
          if (bus.gp_finish) begin
            m_en = 0; m_phase = 2;
          end else if (m_elapsed == Tmo) begin
            m_en = 0; m_tmo = 1; m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
      if (bus.flush) mq.delete();
      else if (bus.push && !was_full && rect_valid(c)) mq.push_back(c);
    end
  end

  // Scoreboard monitor: every new command presented on gp_* must be the next expected one.
  bit   prev_en = 0;
  cmd_t sb_exp;
  always @(negedge clk) begin
    if (bus.gp_en === 1'b1 && !prev_en) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", 64'(cur_gp()), 64'hDEAD);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_issued_cmd", 64'(cur_gp()), 64'(sb_exp));
      end
    end
    prev_en = (bus.gp_en === 1'b1);
  end

  always @(negedge clk) begin
    chk("gp_en", 64'(bus.gp_en), 64'(m_en));
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("full", 64'(bus.full), 64'(mq.size() == Depth));
    chk("busy", 64'(bus.busy), 64'(m_phase != 0 || mq.size() != 0));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("reject", 64'(bus.reject), 64'(m_rej));
    chk("timeout_err", 64'(bus.timeout_err), 64'(m_tmo));
    chk("gp_fields", 64'(cur_gp()), 64'(m_cmd));
  end

  // graphics_processor stand-in.
  bit auto_fin = 0, force_fin = 0, spur_en = 0;
  int lat = 4, fin_cnt = 0;
  initial bus.gp_finish = 1'b0;
  always @(posedge clk) begin
    #2;
    bus.gp_finish = 1'b0;
    if (force_fin) begin
      bus.gp_finish = 1'b1;
      force_fin = 0;
    end else if (auto_fin && bus.gp_en === 1'b1) begin
      if (fin_cnt >= lat) begin
        bus.gp_finish = 1'b1;
        fin_cnt = 0;
      end else begin
        fin_cnt++;
      end
    end else begin
      fin_cnt = 0;
      if (spur_en && $urandom_range(0, 15) == 0) bus.gp_finish = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input cmd_t c);
    {bus.in_opcode, bus.in_tl_x, bus.in_tl_y, bus.in_br_x, bus.in_br_y, bus.in_arg} = c;
  endtask

  task automatic do_push(input cmd_t c);
    set_in(c);
    bus.push = 1'b1;
    step();
    bus.push = 1'b0;
  endtask

  function automatic cmd_t rand_cmd(input bit valid);
    cmd_t c;
    c.opcode = 1'($urandom_range(0, 1));
    c.arg    = 12'($urandom_range(0, 4095));
    c.tl_x   = 10'($urandom_range(0, 639));
    c.br_x   = 10'($urandom_range(int'(c.tl_x), 639));
    c.tl_y   = 9'($urandom_range(0, 479));
    c.br_y   = 9'($urandom_range(int'(c.tl_y), 479));
    if (!valid) begin
      case ($urandom_range(0, 3))
        0: begin
          c.tl_x = 10'($urandom_range(1, 639));
          c.br_x = 10'($urandom_range(0, int'(c.tl_x) - 1));
        end
        1: c.br_x = 10'($urandom_range(640, 1023));
        2: c.br_y = 9'($urandom_range(480, 511));
        default: begin
          c.tl_y = 9'($urandom_range(1, 479));
          c.br_y = 9'($urandom_range(0, int'(c.tl_y) - 1));
        end
      endcase
    end
    return c;
  endfunction

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((m_phase != 0 || mq.size() != 0 || bus.busy !== 1'b0) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_within_budget", 64'(n < maxc), 64'd1);
  endtask

  initial begin
    cmd_t c;
    bus.flush = 1'b0;
    bus.push  = 1'b0;
    set_in('0);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single fill command into an empty FIFO.
    auto_fin = 1; lat = 4;
    c = '{opcode: 1'b0, tl_x: 10'd0, tl_y: 9'd0, br_x: 10'd9, br_y: 9'd9, arg: 12'hF00};
    do_push(c);
    chk("t1_not_yet_issued", 64'(bus.gp_en), 64'd0);
    step();
    chk("t1_issued_fields", 64'(cur_gp()), 64'(c));
    wait_drain(100);

    // Fill to full while the first command is held, then overflow, then drain in order.
    auto_fin = 0;
    for (int i = 0; i < Depth + 2; i++) do_push(rand_cmd(1'b1));
    chk("t2_full", 64'(bus.full), 64'd1);
    chk("t2_overflow", 64'(bus.overflow), 64'd1);
    auto_fin = 1;
    wait_drain(2000);

    // Invalid rectangles are dropped.
    auto_fin = 0;
    c = rand_cmd(1'b1);
    c.tl_x = 10'd100; c.br_x = 10'd50;
    do_push(c);
    c = rand_cmd(1'b1);
    c.br_y = 9'd480;
    do_push(c);
    step();
    chk("t3_reject", 64'(bus.reject), 64'd1);
    chk("t3_count", 64'(bus.count), 64'd0);

    // Watchdog aborts a command that never finishes.
    do_push(rand_cmd(1'b1));
    do_push(rand_cmd(1'b1));
    repeat (25) step();
    chk("t4_timeout_err", 64'(bus.timeout_err), 64'd1);
    wait_drain(200);

    // Flush while a command is in flight.
    for (int i = 0; i < 5; i++) do_push(rand_cmd(1'b1));
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t5_count_flushed", 64'(bus.count), 64'd0);
    chk("t5_inflight_kept", 64'(bus.gp_en), 64'd1);
    repeat (3) step();
    force_fin = 1;
    wait_drain(100);

    // Reset mid-command with a same-cycle push.
    for (int i = 0; i < 5; i++) do_push(rand_cmd(1'b1));
    set_in(rand_cmd(1'b1));
    bus.push = 1'b1;
    rst = 1'b1;
    step();
    bus.push = 1'b0;
    rst = 1'b0;
    chk("t6_gp_en", 64'(bus.gp_en), 64'd0);
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_flags", 64'({bus.overflow, bus.reject, bus.timeout_err}), 64'd0);
    repeat (2) step();
    force_fin = 1;
    repeat (4) step();

    // Randomised traffic.
    auto_fin = 1; spur_en = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) auto_fin = ~auto_fin;
      if ($urandom_range(0, 31) == 0) lat = $urandom_range(0, 6);
      set_in(rand_cmd($urandom_range(0, 7) != 0));
      bus.push  = ($urandom_range(0, 1) == 1);
      bus.flush = ($urandom_range(0, 63) == 0);
      step();
    end
    bus.push = 1'b0; bus.flush = 1'b0;
    auto_fin = 1; spur_en = 0;
    wait_drain(3000);
    step();
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
